// File: rtl/data_sram_resp_if.sv
// Request/response signals of the CPU data SRAM-like bus.
// The requester (CPU) is the master; the memory model is the slave.
interface data_sram_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Responder end of the data SRAM-like bus: byte-masked word array, fixed-latency
// in-order responses, bounded outstanding requests and injectable back-pressure.
module data_sram_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stall_inject,
    data_sram_resp_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int PW        = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW        = $clog2(MAX_OUT + 1);
    localparam int AW        = 4;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [MAX_OUT-1:0] f_vld;
    logic [AW-1:0]      f_age  [0:(1<<PW)-1];
    logic [31:0]        f_data [0:(1<<PW)-1];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic [31:0]        last_rdata;

    logic [DEPTH_LOG2-1:0] idx;
    logic [NUM_LANES-1:0]  size_mask, wen;
    logic                  accept, pop;
    logic                  unused_addr;

    // Upper address bits alias onto the array.
    assign idx         = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{bus.addr[31:DEPTH_LOG2+2]};

    always_comb begin
        size_mask = 4'b1111;
        case (bus.size)
            2'd0:    size_mask = 4'b0001 << bus.addr[1:0];
            2'd1:    size_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign wen         = size_mask & bus.wstrb;
    assign bus.addr_ok = !stall_inject && (count < CW'(MAX_OUT));
    assign accept      = bus.req && bus.addr_ok;
    assign pop         = (count != '0) && (f_age[rd_ptr] == AW'(LATENCY));
    assign bus.data_ok = pop;
    assign bus.rdata   = pop ? f_data[rd_ptr] : last_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Array is deliberately not reset; contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int l = 0; l < NUM_LANES; l++)
                if (wen[l]) mem[idx][8*l +: 8] <= bus.wdata[8*l +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_vld      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_rdata <= '0;
            for (int i = 0; i < (1<<PW); i++) begin
                f_age[i]  <= '0;
                f_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUT; i++)
                if (f_vld[i] && f_age[i] < AW'(LATENCY)) f_age[i] <= f_age[i] + 1'b1;
            if (pop) begin
                f_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
                last_rdata    <= f_data[rd_ptr];
            end
            // A free slot is never the head slot, so push and pop cannot collide.
            if (accept) begin
                f_vld[wr_ptr]  <= 1'b1;
                f_age[wr_ptr]  <= AW'(1);
                f_data[wr_ptr] <= bus.wr ? 32'h0 : mem[idx];
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
